// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the Y86-64 encoder and the fetch stage.
//   - icode constants and the "no register" specifier RNONE
//   - FSM state type for the instruction encoder
//   - need_regids / need_valC: the field-presence rules per icode
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } enc_state_e;

    // Instruction carries a register-specifier byte.
    function automatic logic need_regids(input logic [3:0] icode);
        logic r;
        case (icode)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            IOPQ, IPUSHQ, IPOPQ: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Instruction carries an 8-byte constant word.
    function automatic logic need_valC(input logic [3:0] icode);
        logic r;
        case (icode)
            IIRMOVQ, IRMMOVQ, IMRMOVQ,
            IJXX, ICALL: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// y86_instr_len: combinational length / validity decode of one instruction.
//   icode, ifun  : instruction and function codes
//   has_regids   : register-specifier byte present
//   has_valc     : 8-byte constant present
//   len          : encoded length in bytes (1, 2, 9 or 10)
//   valid        : icode/ifun pair is legal
// Macro Y86_ENC_CHECK_EN enables ifun/icode legality checking; without it
// every pair is reported valid (unknown icodes then encode as one byte).
import y86_pkg::*;

module y86_instr_len (
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       has_regids,
    output logic       has_valc,
    output logic [3:0] len,
    output logic       valid
);

    always_comb begin
        has_regids = need_regids(icode);
        has_valc   = need_valC(icode);
        len        = 4'd1 + {3'b000, has_regids} + (has_valc ? 4'd8 : 4'd0);
    end

`ifdef Y86_ENC_CHECK_EN
    always_comb begin
        valid = 1'b0;
        case (icode)
            IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            ICALL, IRET, IPUSHQ, IPOPQ: valid = (ifun == 4'h0);
            IRRMOVQ, IJXX:              valid = (ifun <= 4'h6);
            IOPQ:                       valid = (ifun <= 4'h3);
            default:                    valid = 1'b0;
        endcase
    end
`else
    logic unused_ifun;
    assign unused_ifun = ^ifun;
    assign valid       = 1'b1;
`endif

endmodule

// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder: serializes decoded Y86-64 instructions into their byte
// encoding and writes them, one byte per cycle, to instruction memory.
//   clk, reset            : clock, asynchronous active-high reset
//   load_addr, start_addr : one-cycle pulse loading the write pointer (IDLE only)
//   in_valid, in_ready    : instruction handshake; fields icode/ifun/rA/rB/valC
//   wr_en/wr_addr/wr_data : byte write port, advanced when wr_ready is high
//   next_pc               : address following the last completed instruction
//   instr_err             : one-cycle pulse, illegal instruction rejected
//   imem_err              : one-cycle pulse, instruction would exceed IMEM_BYTES
// Macro Y86_ENC_CHECK_EN enables instruction legality checking (instr_err).
import y86_pkg::*;

module y86_instr_encoder #(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_addr,
    input  logic [63:0] start_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ready,
    output logic [63:0] next_pc,
    output logic        instr_err,
    output logic        imem_err
);

    enc_state_e  state_q, state_d;
    logic [63:0] ptr_q, ptr_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  len_q, len_d;
    logic        regids_q, regids_d;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  regs_q, regs_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] next_pc_q, next_pc_d;
    logic        instr_err_q, instr_err_d;
    logic        imem_err_q, imem_err_d;

    logic        in_regids;
    logic        in_valc;
    logic [3:0]  in_len;
    logic        in_ok;

    y86_instr_len u_len (
        .icode      (icode),
        .ifun       (ifun),
        .has_regids (in_regids),
        .has_valc   (in_valc),
        .len        (in_len),
        .valid      (in_ok)
    );

    // A same-cycle load is applied before the bounds check, so the
    // instruction is checked and emitted at start_addr.
    logic [63:0] ptr_eff;
    logic [64:0] end_addr;
    logic        out_of_bounds;

    always_comb begin
        ptr_eff       = load_addr ? start_addr : ptr_q;
        end_addr      = {1'b0, ptr_eff} + 65'(in_len);
        out_of_bounds = end_addr > 65'(IMEM_BYTES);
    end

    // Byte mux: opcode byte, optional register byte, then valC little-endian.
    logic [3:0]  valc_idx;
    logic [63:0] valc_shift;
    logic [7:0]  cur_byte;

    always_comb begin
        valc_idx   = idx_q - (regids_q ? 4'd2 : 4'd1);
        valc_shift = valc_q >> {valc_idx[2:0], 3'b000};
        if (idx_q == 4'd0) begin
            cur_byte = byte0_q;
        end else if (regids_q && idx_q == 4'd1) begin
            cur_byte = regs_q;
        end else begin
            cur_byte = valc_shift[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        len_d       = len_q;
        regids_d    = regids_q;
        byte0_d     = byte0_q;
        regs_d      = regs_q;
        valc_d      = valc_q;
        next_pc_d   = next_pc_q;
        instr_err_d = 1'b0;
        imem_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ptr_d = ptr_eff;
                if (in_valid) begin
                    if (!in_ok) begin
                        instr_err_d = 1'b1;
                    end else if (out_of_bounds) begin
                        imem_err_d = 1'b1;
                    end else begin
                        state_d  = ST_EMIT;
                        idx_d    = 4'd0;
                        len_d    = in_len;
                        regids_d = in_regids;
                        byte0_d  = {icode, ifun};
                        regs_d   = {rA, rB};
                        valc_d   = valC;
                    end
                end
            end
            ST_EMIT: begin
                if (wr_ready) begin
                    ptr_d = ptr_q + 64'd1;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == len_q - 4'd1) begin
                        next_pc_d = ptr_q + 64'd1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            regids_q    <= 1'b0;
            byte0_q     <= '0;
            regs_q      <= '0;
            valc_q      <= '0;
            next_pc_q   <= '0;
            instr_err_q <= 1'b0;
            imem_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            regids_q    <= regids_d;
            byte0_q     <= byte0_d;
            regs_q      <= regs_d;
            valc_q      <= valc_d;
            next_pc_q   <= next_pc_d;
            instr_err_q <= instr_err_d;
            imem_err_q  <= imem_err_d;
        end
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
        wr_en    = (state_q == ST_EMIT);
        wr_addr  = ptr_q;
        wr_data  = wr_en ? cur_byte : 8'h00;
        next_pc  = next_pc_q;
        imem_err = imem_err_q;
    end

`ifdef Y86_ENC_CHECK_EN
    assign instr_err = instr_err_q;
`else
    logic unused_instr_err;
    assign unused_instr_err = instr_err_q;
    assign instr_err        = 1'b0;
`endif

endmodule

// File: tb/tb_y86_instr_encoder.sv
module tb_y86_instr_encoder;

    localparam int unsigned IMEM = 1024;
`ifdef Y86_ENC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        load_addr;
    logic [63:0] start_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [63:0] next_pc;
    logic        instr_err;
    logic        imem_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_ptr;
    logic [63:0] model_next_pc;

    always #5 clk = ~clk;

    y86_instr_encoder #(.IMEM_BYTES(IMEM)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_addr  (load_addr),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .next_pc    (next_pc),
        .instr_err  (instr_err),
        .imem_err   (imem_err)
    );

    // ---------------- reference model (from the instruction-set rules) -----
    function automatic bit ref_valid(input logic [3:0] ic, input logic [3:0] fn);
        int max_ifun [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
        if (!CHECK_EN) return 1'b1;
        return int'(fn) <= max_ifun[ic];
    endfunction

    function automatic int ref_len(input logic [3:0] ic);
        int n = 1;
        if (ic inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11}) n += 1;
        if (ic inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8}) n += 8;
        return n;
    endfunction

    // Drive one instruction and follow it to completion (or rejection).
    // stall_mode: 0 = wr_ready high, 1 = low on alternate cycles, 2 = random.
    // Enters and leaves at 1 time unit after a rising edge.
    task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] vc, input int stall_mode,
                             input bit do_load, input logic [63:0] la,
                             input string name);
        logic [7:0] exp_bytes[$];
        int  len, n, cyc, w;
        bit  ok, oob;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", name, in_ready);
        end

        icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
        in_valid = 1'b1; load_addr = do_load; start_addr = la;
        if (do_load) model_ptr = la;

        len = ref_len(ic);
        ok  = ref_valid(ic, fn);
        oob = (model_ptr > 64'(IMEM - len));
        exp_bytes.delete();
        exp_bytes.push_back({ic, fn});
        if (len == 2 || len == 10) exp_bytes.push_back({ra, rb});
        if (len >= 9) for (int i = 0; i < 8; i++) exp_bytes.push_back(vc[8*i +: 8]);

        @(posedge clk); #1;
        in_valid = 1'b0; load_addr = 1'b0;

        if (!ok || oob) begin
            #3;
            checks++;
            if (instr_err !== !ok || imem_err !== (ok && oob) || wr_en !== 1'b0) begin
                errors++;
                $display("FAIL %s err_pulse: instr_err=%b imem_err=%b wr_en=%b required %b %b 0",
                         name, instr_err, imem_err, wr_en, !ok, ok && oob);
            end
            @(posedge clk); #1; #3;
            checks++;
            if (instr_err !== 1'b0 || imem_err !== 1'b0 || wr_en !== 1'b0 ||
                in_ready !== 1'b1 || next_pc !== model_next_pc) begin
                errors++;
                $display("FAIL %s err_end: ierr=%b merr=%b wr_en=%b rdy=%b next_pc=%h required 0 0 0 1 %h",
                         name, instr_err, imem_err, wr_en, in_ready, next_pc, model_next_pc);
            end
            @(posedge clk); #1;
            return;
        end

        n = 0; cyc = 0;
        while (n < len && cyc < 200) begin
            case (stall_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (cyc % 2) == 1;
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
            #3;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== model_ptr + 64'(n) || wr_data !== exp_bytes[n]) begin
                errors++;
                $display("FAIL %s byte%0d: wr_en=%b addr=%h data=%h required 1 %h %h",
                         name, n, wr_en, wr_addr, wr_data, model_ptr + 64'(n), exp_bytes[n]);
            end
            if (wr_ready) n++;
            @(posedge clk); #1;
            cyc++;
        end
        wr_ready = 1'b1;
        checks++;
        if (n != len || (stall_mode == 0 && cyc != len)) begin
            errors++;
            $display("FAIL %s byte_count: accepted=%0d cycles=%0d required %0d", name, n, cyc, len);
        end
        model_ptr     = model_ptr + 64'(len);
        model_next_pc = model_ptr;
        #3;
        checks++;
        if (in_ready !== 1'b1 || wr_en !== 1'b0 || next_pc !== model_next_pc) begin
            errors++;
            $display("FAIL %s done: in_ready=%b wr_en=%b next_pc=%h required 1 0 %h",
                     name, in_ready, wr_en, next_pc, model_next_pc);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 64'h0 || wr_data !== 8'h00 || in_ready !== 1'b1 ||
            next_pc !== 64'h0 || instr_err !== 1'b0 || imem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: wr_en=%b addr=%h data=%h rdy=%b next_pc=%h ierr=%b merr=%b required 0 0 0 1 0 0 0",
                     wr_en, wr_addr, wr_data, in_ready, next_pc, instr_err, imem_err);
        end
        reset = 1'b0;
        model_ptr = '0; model_next_pc = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_instr(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 0, 1'b0, 64'h0, "halt");
        run_instr(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 0, 1'b1, 64'h100, "irmovq");
        run_instr(4'h6, 4'h7, 4'h1, 4'h2, 64'h0, 0, 1'b0, 64'h0, "opq_ifun7");
        run_instr(4'h2, 4'h3, 4'h4, 4'h5, 64'h0, 0, 1'b0, 64'h0, "cmovxx");
        run_instr(4'h7, 4'h1, 4'hF, 4'hF, 64'h40, 1, 1'b1, 64'h200, "jxx_stall");
        run_instr(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 1, 1'b0, 64'h0, "pushq_stall");
    endtask

    task automatic test_load_only();
        load_addr = 1'b1; start_addr = 64'h300;
        @(posedge clk); #1;
        load_addr = 1'b0;
        model_ptr = 64'h300;
        run_instr(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 0, 1'b0, 64'h0, "nop_after_load");
    endtask

    task automatic test_bounds();
        run_instr(4'h8, 4'h0, 4'hF, 4'hF, 64'h123, 0, 1'b1, 64'(IMEM - 5), "call_oob");
        run_instr(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 0, 1'b1, 64'(IMEM - 1), "ret_last");
        run_instr(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 0, 1'b0, 64'h0, "ret_full");
        run_instr(4'h3, 4'h0, 4'hF, 4'h1, 64'h5, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, "irmovq_wrap");
        run_instr(4'h5, 4'h0, 4'h1, 4'h2, 64'h8, 0, 1'b1, 64'(IMEM - 10), "mrmovq_fit");
        run_instr(4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 0, 1'b1, 64'h20, "icode_f");
    endtask

    task automatic test_back_to_back();
        run_instr(4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 0, 1'b1, 64'h10, "b2b_popq");
        run_instr(4'h6, 4'h2, 4'h3, 4'h4, 64'h0, 0, 1'b0, 64'h0, "b2b_opq");
        run_instr(4'h8, 4'h0, 4'hF, 4'hF, 64'hDEAD_BEEF_0000_1234, 0, 1'b0, 64'h0, "b2b_call");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  ic, fn;
            logic [63:0] la;
            bit          ld;
            ic = 4'($urandom_range(0, 15));
            fn = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ld = ($urandom_range(0, 3) == 0) || (model_ptr > 64'(IMEM - 40));
            la = ($urandom_range(0, 4) == 0) ? 64'(IMEM - $urandom_range(0, 12))
                                             : 64'($urandom_range(0, IMEM - 100));
            run_instr(ic, fn, 4'($urandom), 4'($urandom), {$urandom, $urandom},
                      2, ld, la, "random");
        end
    endtask

    task automatic test_reset_mid_emit();
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        icode = 4'h4; ifun = 4'h0; rA = 4'h1; rB = 4'h2; valC = 64'h1122334455667788;
        in_valid = 1'b1; load_addr = 1'b1; start_addr = 64'h80;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; load_addr = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 64'h83 || wr_data !== 8'h77) begin
            errors++;
            $display("FAIL mid_emit_byte3: wr_en=%b addr=%h data=%h required 1 83 77",
                     wr_en, wr_addr, wr_data);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 64'h0 || in_ready !== 1'b1 || next_pc !== 64'h0 ||
            wr_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_emit_reset: wr_en=%b addr=%h rdy=%b next_pc=%h data=%h required 0 0 1 0 0",
                     wr_en, wr_addr, in_ready, next_pc, wr_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_ptr = '0; model_next_pc = '0;
        @(posedge clk); #1;
        run_instr(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 0, 1'b0, 64'h0, "halt_after_reset");
    endtask

    initial begin
        reset = 1'b1; load_addr = 1'b0; start_addr = '0; in_valid = 1'b0;
        icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0; wr_ready = 1'b1;
        model_ptr = '0; model_next_pc = '0;
        #1;
        test_reset();
        test_directed();
        test_load_only();
        test_bounds();
        test_back_to_back();
        test_random();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
